// File: rtl/uart_rx_parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the 8-bit UART link
//                (receiver state encoding, default sizes, parity selects).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Receiver state encoding
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   // Parity selects, identical meaning on transmit and receive side
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_parity_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_parity_if
//  Description : Line-side inputs and byte-side results of the UART receiver.
//                master = stimulus/consumer side, slave = receiver side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_parity_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
);
   logic                 baud_tick;
   logic                 rx;
   logic                 parity_type;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output baud_tick, rx, parity_type,
      input  data_out, data_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  baud_tick, rx, parity_type,
      output data_out, data_valid, parity_err, frame_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_parity_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchroniser with configurable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic d,
   output logic      q
);
   logic meta;

   // Two back-to-back flops give the first stage a full cycle to settle
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule
`default_nettype wire

// File: rtl/uart_rx_parity.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_parity
//  Description : UART receiver, 1 start / DATA_BITS data (LSB first) /
//                1 parity / 1 stop. Mid-bit sampling on an oversampled
//                baud strobe; reports byte plus parity and framing errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_parity
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  wire logic         clk,
   input  wire logic         rst,
   uart_rx_parity_if.slave   bus
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   state_t               state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 perr;
   logic                 rx_s;
   logic                 rx_d;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx),
      .q   (rx_s)
   );

   // Frame FSM: edge-triggered start, mid-bit sampling, registered results
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         perr       <= 1'b0;
         rx_d       <= 1'b1;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_d       <= rx_s;
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               // Only a genuine high-to-low transition starts a frame
               if (rx_d && !rx_s) begin
                  state    <= START;
                  tick_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            START: begin
               if (bus.baud_tick) begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     if (!rx_s) begin
                        state <= DATA;
                     end else begin
                        // Line back high at mid start bit: a glitch
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (bus.baud_tick) begin
                  if (tick_cnt == TICK_END) begin
                     tick_cnt           <= '0;
                     shift_reg[bit_cnt] <= rx_s;
                     if (bit_cnt == LAST_BIT) begin
                        state <= PARITY;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bus.baud_tick) begin
                  if (tick_cnt == TICK_END) begin
                     tick_cnt <= '0;
                     perr     <= (rx_s != ((^shift_reg) ^ bus.parity_type));
                     state    <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (bus.baud_tick) begin
                  if (tick_cnt == TICK_END) begin
                     // Back to IDLE at mid stop bit so a following start
                     // edge in the second half is still caught
                     tick_cnt   <= '0;
                     data_out   <= shift_reg;
                     parity_err <= perr;
                     frame_err  <= ~rx_s;
                     data_valid <= 1'b1;
                     state      <= IDLE;
                     busy       <= 1'b0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out   = data_out;
   assign bus.data_valid = data_valid;
   assign bus.parity_err = parity_err;
   assign bus.frame_err  = frame_err;
   assign bus.busy       = busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_parity.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_parity
//  Description : Self-checking bench for uart_rx_parity: directed frames plus
//                random frames, compared against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_parity;
   import uart_pkg::*;

   localparam int OS      = 16;
   localparam int TICKDIV = 4;

   typedef struct {
      logic [7:0] d;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   div_cnt  = 0;
   logic prev_valid = 1'b0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   uart_rx_parity_if #(.DATA_BITS(8)) bus ();

   uart_rx_parity #(
      .OVERSAMPLE (OS),
      .DATA_BITS  (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Baud strobe: one clk high out of every TICKDIV
   initial begin
      bus.baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         bus.baud_tick = (div_cnt == TICKDIV - 1);
         div_cnt       = (div_cnt + 1) % TICKDIV;
      end
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!bus.baud_tick) @(posedge clk);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      @(negedge clk);
      bus.rx = v;
      wait_ticks(n);
   endtask

   // Frame-level model: expected parity from the data and the selected type
   task automatic send_frame(input logic [7:0] d, input logic ptype, input logic pbit,
                             input logic stopb, input int stop_ticks);
      exp_t e;
      int   ones;
      logic want;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += d[i];
      want   = (ptype == PARITY_EVEN) ? logic'(ones % 2) : logic'(1 - ones % 2);
      e.d    = d;
      e.perr = (pbit != want);
      e.ferr = !stopb;
      exp_q.push_back(e);
      @(negedge clk);
      bus.parity_type = ptype;
      drive_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) drive_bit(d[i], OS);
      drive_bit(pbit, OS);
      drive_bit(stopb, stop_ticks);
   endtask

   // Output monitor: every data_valid must match the oldest expected frame
   initial begin
      forever begin
         @(negedge clk);
         if (bus.data_valid) begin
            check("valid_width", {31'b0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
               check("spurious_valid", {31'b0, bus.data_valid}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("data_out", {24'b0, bus.data_out}, {24'b0, e.d});
               check("parity_err", {31'b0, bus.parity_err}, {31'b0, e.perr});
               check("frame_err", {31'b0, bus.frame_err}, {31'b0, e.ferr});
            end
         end
         prev_valid = bus.data_valid;
      end
   end

   initial begin
      logic [7:0] rd;
      logic       rp, rb, rs;
      int         gap;

      rst             = 1'b1;
      bus.rx          = 1'b1;
      bus.parity_type = PARITY_EVEN;
      repeat (5) @(negedge clk);
      check("rst_data_out", {24'b0, bus.data_out}, 32'd0);
      check("rst_data_valid", {31'b0, bus.data_valid}, 32'd0);
      check("rst_parity_err", {31'b0, bus.parity_err}, 32'd0);
      check("rst_frame_err", {31'b0, bus.frame_err}, 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      rst = 1'b0;
      wait_ticks(4);

      // Even parity, clean frame
      send_frame(8'hA5, PARITY_EVEN, 1'b0, 1'b1, OS);
      check("pending_even", exp_q.size(), 32'd0);

      // Odd parity, wrong then right parity bit
      send_frame(8'hA5, PARITY_ODD, 1'b0, 1'b1, OS);
      send_frame(8'hA5, PARITY_ODD, 1'b1, 1'b1, OS);
      check("pending_odd", exp_q.size(), 32'd0);

      // Framing error, then recovery once the line returns high
      send_frame(8'h3C, PARITY_EVEN, 1'b0, 1'b0, OS);
      drive_bit(1'b1, 4);
      send_frame(8'h01, PARITY_EVEN, 1'b1, 1'b1, OS);
      check("pending_frame", exp_q.size(), 32'd0);

      // Start-bit glitch: 4 ticks low, then high
      drive_bit(1'b1, 4);
      drive_bit(1'b0, 4);
      @(negedge clk);
      check("glitch_busy_hi", {31'b0, bus.busy}, 32'd1);
      bus.rx = 1'b1;
      wait_ticks(4);
      @(negedge clk);
      check("glitch_busy_lo", {31'b0, bus.busy}, 32'd0);
      check("glitch_hold", {24'b0, bus.data_out}, 32'h01);
      wait_ticks(8);

      // Back-to-back frames, next start edge at stop-bit tick 10
      send_frame(8'h00, PARITY_ODD, 1'b1, 1'b1, 10);
      send_frame(8'hFF, PARITY_ODD, 1'b1, 1'b1, OS);
      check("pending_b2b", exp_q.size(), 32'd0);

      // Reset during data bit 4 aborts the frame
      drive_bit(1'b0, OS);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, OS);
      drive_bit(1'b0, 8);
      @(negedge clk);
      check("mid_busy", {31'b0, bus.busy}, 32'd1);
      rst    = 1'b1;
      bus.rx = 1'b1;
      repeat (2) @(negedge clk);
      check("mrst_data_out", {24'b0, bus.data_out}, 32'd0);
      check("mrst_parity_err", {31'b0, bus.parity_err}, 32'd0);
      check("mrst_frame_err", {31'b0, bus.frame_err}, 32'd0);
      check("mrst_busy", {31'b0, bus.busy}, 32'd0);
      check("mrst_valid", {31'b0, bus.data_valid}, 32'd0);
      rst = 1'b0;
      wait_ticks(20);
      send_frame(8'h5A, PARITY_EVEN, 1'b0, 1'b1, OS);
      check("pending_rst", exp_q.size(), 32'd0);

      // Random frames
      for (int k = 0; k < 16; k++) begin
         rd  = 8'($urandom_range(0, 255));
         rp  = 1'($urandom_range(0, 1));
         rb  = 1'($urandom_range(0, 1));
         rs  = ($urandom_range(0, 3) != 0);
         gap = rs ? $urandom_range(0, 3) : $urandom_range(2, 4);
         send_frame(rd, rp, rb, rs, OS);
         if (gap > 0) drive_bit(1'b1, gap);
      end
      drive_bit(1'b1, 4);
      check("pending_rand", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- Serial receiver for the 8-bit UART link; the receive-side counterpart to the transmit parity generator.
- Deserialises frames of 1 start bit, 8 data bits LSB first, 1 parity bit and 1 stop bit.
- Checks the parity bit using the same even/odd convention as the transmitter: expected parity is ^data when even, ~^data when odd.
- Sits between the rx pin (via an internal synchroniser) and the consumer logic; presents one byte plus error flags per frame.

Parameters:
- OVERSAMPLE, 16, baud_tick strobes per bit period; must be even and >= 4.
- DATA_BITS, 8, payload bits per frame; the team uses 8 only.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset. One clock domain only.
- baud_tick, input, 1, single-cycle strobe at OVERSAMPLE x baud rate.
- rx, input, 1, asynchronous serial line; idles high.
- parity_type, input, 1, 0 = even, 1 = odd. Sampled at the parity-bit sample point.
- data_out, output, DATA_BITS, last received byte; holds until the next frame completes.
- data_valid, output, 1, one-clk pulse when a frame completes.
- parity_err, output, 1, parity mismatch for the frame reported with data_valid; held until the next completion.
- frame_err, output, 1, stop bit sampled low; held until the next completion.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, sync flops=1, counters=0. Reset mid-frame aborts the frame with no data_valid.
- rx passes through a 2-flop synchroniser (reset to 1), giving rx_s. Start detection uses rx_s plus one more registered copy, rx_d.
- States are IDLE, START, DATA, PARITY, STOP.
- tick_cnt counts baud_tick only; all other clk cycles hold state.
- IDLE: falling edge (rx_d=1, rx_s=0) -> START with tick_cnt=0. A line held low with no edge never starts a frame.
- START: after OVERSAMPLE/2 ticks (mid-bit), sample rx_s.
  - rx_s=0 -> DATA with bit_cnt=0 and tick_cnt=0.
  - rx_s=1 -> IDLE, treated as a glitch with no output.
- DATA: every OVERSAMPLE ticks, sample rx_s into shift_reg[bit_cnt]. After bit DATA_BITS-1 -> PARITY.
- PARITY: sample after OVERSAMPLE ticks. calc = (^shift_reg) ^ parity_type. Register perr = (rx_s != calc). -> STOP.
- STOP: sample after OVERSAMPLE ticks, then in the same clk:
  - data_out <= shift_reg
  - parity_err <= perr
  - frame_err <= ~rx_s
  - data_valid <= 1
  - state -> IDLE
- Latency: data_valid rises on the clk edge after the stop-bit mid-sample baud_tick. It is high for exactly one clk.
- Early return to IDLE lets a back-to-back start edge be detected in the second half of the stop bit.
- After a frame error (rx still low), the next frame needs rx to return high and then fall again.
- Errors do not suppress data_valid; the consumer decides whether to drop the byte.
- parity_type changes between frames are allowed; a change during the parity bit uses the value at the sample tick.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP}
  - OVERSAMPLE_DEF=16 and DATA_BITS_DEF=8
  - PARITY_EVEN=1'b0 and PARITY_ODD=1'b1, shared with the transmitter
- One natural sub-module, sync_2ff: 1-bit 2-flop synchroniser with a reset value parameter. The rest is a single FSM plus counters.

Test Plan:
- Even parity, send 0xA5 with parity bit 0 and stop 1 -> data_out=0xA5, data_valid one-clk pulse, parity_err=0, frame_err=0.
- Odd parity, send 0xA5 with parity bit 0 -> data_out=0xA5, parity_err=1. Resend with parity bit 1 -> parity_err=0.
- Even parity, send 0x3C with parity bit 0 and stop bit 0 -> data_out=0x3C, frame_err=1, parity_err=0. A following 0x01 frame after rx returns high -> frame_err=0.
- rx low for 4 ticks then high (glitch) -> no data_valid, busy returns to 0 after OVERSAMPLE/2 ticks, no state corruption.
- Two back-to-back frames, 0x00 then 0xFF, odd parity, start edge at stop-bit tick 10 -> two data_valid pulses with data_out 0x00 then 0xFF, no errors.
- Assert rst during DATA bit 4 -> all outputs 0, no data_valid. A following 0x5A frame is received correctly.
